// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes,
// FSM state codes and the alignment rule applied at request accept.
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_READ  = ST_READ,
        S_WRITE = ST_WRITE,
        S_RESP  = ST_RESP
    } lsu_state_t;

    // Illegal size encodings are folded in so a single check covers every fault.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
interface load_store_unit_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;

    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, mem_a, mem_we, mem_wd
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, mem_a, mem_we, mem_wd
    );

endinterface

// File: rtl/lsu_byte_lane.sv
// Little-endian lane steering: extracts/extends a load result from a memory word
// and merges sub-word store data into a previously read word.
import lsu_pkg::*;

module lsu_byte_lane (
    input  logic [31:0] rd_word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] load_data,
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    output logic [31:0] merged
);

    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] spread;

    always_comb begin
        shifted   = rd_word >> {offset, 3'b000};
        load_data = rd_word;
        case (size)
            SIZE_BYTE: load_data = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_data = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            default:   load_data = rd_word;
        endcase
    end

    // Replicate the store data across all lanes, then let the mask pick the target lane.
    always_comb begin
        mask   = '1;
        spread = new_data;
        case (size)
            SIZE_BYTE: begin
                mask   = 32'h0000_00FF << {offset, 3'b000};
                spread = {4{new_data[7:0]}};
            end
            SIZE_HALF: begin
                mask   = 32'h0000_FFFF << {offset[1], 4'b0000};
                spread = {2{new_data[15:0]}};
            end
            default: begin
                mask   = '1;
                spread = new_data;
            end
        endcase
        merged = (old_word & ~mask) | (spread & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: IDLE/READ/WRITE/RESP FSM between the memory
// stage and a word-addressed data memory; sub-word stores use read-modify-write.
import lsu_pkg::*;

module load_store_unit (
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        mis_q;

    logic [31:0] load_data;
    logic [31:0] merged;

    lsu_byte_lane u_lane (
        .rd_word   (bus.mem_rd),
        .offset    (addr_q[1:0]),
        .size      (size_q),
        .is_signed (signed_q),
        .load_data (load_data),
        .old_word  (word_q),
        .new_data  (wdata_q),
        .merged    (merged)
    );

    // Response registers only change on the edge entering RESP, so they hold between responses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q   <= bus.req_addr;
                        write_q  <= bus.req_write;
                        size_q   <= bus.req_size;
                        signed_q <= bus.req_signed;
                        wdata_q  <= bus.req_wdata;
                        if (lsu_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            state   <= S_RESP;
                            rdata_q <= '0;
                            mis_q   <= 1'b1;
                        end else if (bus.req_write && bus.req_size == SIZE_WORD) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    word_q <= bus.mem_rd;
                    if (write_q) begin
                        state <= S_WRITE;
                    end else begin
                        state   <= S_RESP;
                        rdata_q <= load_data;
                        mis_q   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    state   <= S_RESP;
                    rdata_q <= '0;
                    mis_q   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready       = (state == S_IDLE) && !reset;
    assign bus.resp_valid      = (state == S_RESP);
    assign bus.resp_rdata      = rdata_q;
    assign bus.resp_misaligned = mis_q;

    always_comb begin
        bus.mem_a  = '0;
        bus.mem_wd = '0;
        bus.mem_we = 1'b0;
        if (state == S_READ || state == S_WRITE) begin
            bus.mem_a = {addr_q[31:2], 2'b00};
        end
        if (state == S_WRITE) begin
            bus.mem_wd = merged;
            bus.mem_we = !reset;
        end
    end

endmodule
